// File: rtl/wm8960_init_ctrl_if.sv
// Write-request handshake between the WM8960 init sequencer and the I2C write master.
// One request carries a device address and two data bytes; done/nack close it.
interface wm8960_init_ctrl_if;
  logic       req;
  logic [7:0] dev_id;
  logic [7:0] byte0;
  logic [7:0] byte1;
  logic       done;
  logic       nack;

  modport master (output req, dev_id, byte0, byte1, input done, nack);
  modport slave  (input req, dev_id, byte0, byte1, output done, nack);
endinterface

// File: rtl/wm8960_init_ctrl.sv
// WM8960 power-up sequencer: waits the power-up delay, then writes every init-table word
// to the codec over I2C, with a long settle after soft reset and bounded NACK retries.
module wm8960_init_ctrl #(
  parameter int PWRUP_CYCLES = 50000,
  parameter int RESET_DLY    = 500000,
  parameter int GAP_CYCLES   = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start,
  output logic [7:0]                o_lut_addr,
  input  logic [15:0]               i_lut_q,
  input  logic [7:0]                i_lut_size,
  input  logic [7:0]                i_dev_id,
  wm8960_init_ctrl_if.master        i2c,
  output logic                      o_init_busy,
  output logic                      o_init_done,
  output logic                      o_init_err,
  output logic [7:0]                o_err_index
);

  typedef enum logic [2:0] {
    S_PWRUP, S_FETCH, S_LATCH, S_WRITE, S_POST, S_DONE, S_ERROR
  } state_t;

  localparam logic [23:0] LP_PWRUP       = 24'(PWRUP_CYCLES);
  localparam logic [23:0] LP_RESET_DLY   = 24'(RESET_DLY);
  localparam logic [23:0] LP_GAP         = 24'(GAP_CYCLES);
  localparam logic [7:0]  LP_MAX_RETRY   = 8'(MAX_RETRY);
  localparam logic [6:0]  LP_SOFT_RST_RA = 7'h0F;

  state_t      r_state, w_state;
  logic [23:0] r_cnt, w_cnt;
  logic [7:0]  r_idx, w_idx;
  logic [7:0]  r_retry, w_retry;
  logic        r_req, w_req;
  logic [7:0]  r_dev, w_dev;
  logic [7:0]  r_b0, w_b0;
  logic [7:0]  r_b1, w_b1;
  logic [7:0]  r_err_idx, w_err_idx;

  logic [23:0] w_delay_lim;
  logic        w_cnt_last;
  logic        w_idx_last;

  // A delay of N keeps the state for N full cycles; N=0 still costs one pass-through cycle.
  assign w_delay_lim = (r_state != S_POST)            ? LP_PWRUP :
                       (r_b0[7:1] == LP_SOFT_RST_RA)  ? LP_RESET_DLY : LP_GAP;
  assign w_cnt_last  = ({1'b0, r_cnt} + 25'd1) >= {1'b0, w_delay_lim};
  // Compared in 9 bits so a 255-entry table ends cleanly without idx wrapping.
  assign w_idx_last  = ({1'b0, r_idx} + 9'd1) == {1'b0, i_lut_size};

  always_comb begin
    // NOTE: every next-value signal takes a default first so no branch can infer a latch.
    w_state   = r_state;
    w_cnt     = '0;
    w_idx     = r_idx;
    w_retry   = r_retry;
    w_req     = r_req;
    w_dev     = r_dev;
    w_b0      = r_b0;
    w_b1      = r_b1;
    w_err_idx = r_err_idx;
    case (r_state)
      S_PWRUP: begin
        if (w_cnt_last) begin
          w_idx   = '0;
          w_state = (i_lut_size == 8'd0) ? S_DONE : S_FETCH;
        end else begin
          w_cnt = r_cnt + 24'd1;
        end
      end
      S_FETCH: w_state = S_LATCH;
      S_LATCH: begin
        w_b0    = i_lut_q[15:8];
        w_b1    = i_lut_q[7:0];
        w_dev   = i_dev_id;
        w_retry = '0;
        w_state = S_WRITE;
      end
      S_WRITE: begin
        // req is registered, so it only rises on the edge after done has gone away.
        if (i2c.done) begin
          w_req = 1'b0;
          if (!i2c.nack) begin
            w_state = S_POST;
          end else if (r_retry < LP_MAX_RETRY) begin
            w_retry = r_retry + 8'd1;
          end else begin
            w_err_idx = r_idx;
            w_state   = S_ERROR;
          end
        end else begin
          w_req = 1'b1;
        end
      end
      S_POST: begin
        if (w_cnt_last) begin
          if (w_idx_last) begin
            w_state = S_DONE;
          end else begin
            w_idx   = r_idx + 8'd1;
            w_state = S_FETCH;
          end
        end else begin
          w_cnt = r_cnt + 24'd1;
        end
      end
      S_DONE, S_ERROR: begin
        if (i_start) begin
          w_idx     = '0;
          w_err_idx = '0;
          w_state   = (i_lut_size == 8'd0) ? S_DONE : S_FETCH;
        end
      end
      default: w_state = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    if (!reset_n) begin
      r_state   <= S_PWRUP;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_retry   <= '0;
      r_req     <= 1'b0;
      r_dev     <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_err_idx <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_retry   <= w_retry;
      r_req     <= w_req;
      r_dev     <= w_dev;
      r_b0      <= w_b0;
      r_b1      <= w_b1;
      r_err_idx <= w_err_idx;
    end
  end

  assign o_lut_addr  = r_idx;
  assign i2c.req     = r_req;
  assign i2c.dev_id  = r_dev;
  assign i2c.byte0   = r_b0;
  assign i2c.byte1   = r_b1;
  assign o_init_busy = (r_state != S_DONE) && (r_state != S_ERROR);
  assign o_init_done = (r_state == S_DONE);
  assign o_init_err  = (r_state == S_ERROR);
  assign o_err_index = r_err_idx;

endmodule

// File: tb/tb_wm8960_init_ctrl.sv
// Self-checking bench for wm8960_init_ctrl: a ROM and an I2C slave model drive the DUT and a
// write-list model (expected bytes plus cycle gaps between bus events) judges every request.
module tb_wm8960_init_ctrl;
  localparam int P_PWRUP = 10;
  localparam int P_RST   = 100;
  localparam int P_GAP   = 16;
  localparam int P_RETRY = 3;
  localparam int BUDGET  = 20000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  lut_addr;
  logic [15:0] lut_q = '0;
  logic [7:0]  lut_size = '0;
  logic [7:0]  dev_id = '0;
  logic        busy, done, err;
  logic [7:0]  err_index;

  wm8960_init_ctrl_if bus();

  wm8960_init_ctrl #(
    .PWRUP_CYCLES(P_PWRUP), .RESET_DLY(P_RST), .GAP_CYCLES(P_GAP), .MAX_RETRY(P_RETRY)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (i_start),
    .o_lut_addr (lut_addr),
    .i_lut_q    (lut_q),
    .i_lut_size (lut_size),
    .i_dev_id   (dev_id),
    .i2c        (bus),
    .o_init_busy(busy),
    .o_init_done(done),
    .o_init_err (err),
    .o_err_index(err_index)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int g_anchor = 0;

  logic [15:0] rom [256];
  int plan [256];       // NACKs to give before ACK, per entry (> P_RETRY means never ACK)
  int nack_left [256];
  int sl_entry = 0;
  int sl_lat = 20;
  bit sl_busy = 0;
  int sl_cnt = 0;

  typedef struct {
    int         gap;
    logic [7:0] b0;
    logic [7:0] b1;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    lut_q <= rom[lut_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // I2C write master stand-in: answers each request sl_lat cycles later.
  initial begin
    bus.done = 1'b0;
    bus.nack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sl_busy  = 0;
        bus.done = 1'b0;
        bus.nack = 1'b0;
      end else if (bus.done) begin
        bus.done = 1'b0;
        bus.nack = 1'b0;
      end else if (sl_busy) begin
        if (sl_cnt <= 1) begin
          bus.done = 1'b1;
          sl_busy  = 0;
          if (nack_left[sl_entry] > 0) begin
            bus.nack = 1'b1;
            nack_left[sl_entry]--;
          end else begin
            bus.nack = 1'b0;
            sl_entry++;
          end
        end else begin
          sl_cnt--;
        end
      end else if (bus.req) begin
        sl_busy = 1;
        sl_cnt  = sl_lat;
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = 16'($urandom);
      plan[i] = 0;
    end
  endtask

  task automatic setup(input int size, input int lat, input logic [7:0] dev);
    lut_size = 8'(size);
    sl_lat   = lat;
    dev_id   = dev;
    sl_entry = 0;
    for (int i = 0; i < 256; i++) nack_left[i] = plan[i];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start  = 1'b1;
    g_anchor = cyc + 1;
    @(negedge clk);
    i_start  = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n  = 1'b1;
    g_anchor = cyc;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},     32'(bus.req),    32'd0);
    check({tag, "_busy"},    32'(busy),       32'd1);
    check({tag, "_done"},    32'(done),       32'd0);
    check({tag, "_err"},     32'(err),        32'd0);
    check({tag, "_err_idx"}, 32'(err_index),  32'd0);
    check({tag, "_lut_addr"},32'(lut_addr),   32'd0);
    check({tag, "_byte0"},   32'(bus.byte0),  32'd0);
    check({tag, "_byte1"},   32'(bus.byte1),  32'd0);
    check({tag, "_dev"},     32'(bus.dev_id), 32'd0);
  endtask

  // Builds the expected write list from the table and NACK plan, then follows the bus.
  // Gaps are cycles from the previous anchor (reset release, start, or req falling).
  task automatic run_seq(input string tag, input int first_gap, input int inj);
    int         pend, end_gap, anchor, rises, hi_cycles, exp_eidx;
    bit         exp_err, fin, prev_req;
    logic [7:0] sb0, sb1;
    wr_t        e;
    exp_q.delete();
    pend     = first_gap;
    exp_err  = 0;
    exp_eidx = 0;
    for (int i = 0; i < int'(lut_size) && !exp_err; i++) begin
      int att;
      att = (plan[i] > P_RETRY) ? P_RETRY + 1 : plan[i] + 1;
      for (int a = 0; a < att; a++) begin
        e.gap = (a == 0) ? pend : 1;
        e.b0  = rom[i][15:8];
        e.b1  = rom[i][7:0];
        exp_q.push_back(e);
      end
      if (plan[i] > P_RETRY) begin
        exp_err  = 1;
        exp_eidx = i;
      end else begin
        pend = ((rom[i][15:9] == 7'h0F) ? P_RST : P_GAP) + 3;
      end
    end
    end_gap  = exp_err ? 0 : pend - 3;
    anchor   = g_anchor;
    rises    = 0;
    fin      = 0;
    prev_req = bus.req;
    sb0      = '0;
    sb1      = '0;
    for (int t = 0; t < BUDGET && !fin; t++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (bus.req && !prev_req) begin
        rises++;
        if (exp_q.size() == 0) begin
          check({tag, "_extra_req"}, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_gap"},   32'(cyc - anchor), 32'(e.gap));
          check({tag, "_byte0"}, 32'(bus.byte0),    32'(e.b0));
          check({tag, "_byte1"}, 32'(bus.byte1),    32'(e.b1));
          check({tag, "_dev"},   32'(bus.dev_id),   32'(dev_id));
        end
        sb0 = bus.byte0;
        sb1 = bus.byte1;
        if (rises == inj) i_start = 1'b1;
      end
      if (!bus.req && prev_req) begin
        anchor = cyc;
        check({tag, "_stable"}, {16'd0, bus.byte0, bus.byte1}, {16'd0, sb0, sb1});
      end
      if (done || err) begin
        fin = 1;
        check({tag, "_end_gap"}, 32'(cyc - anchor), 32'(end_gap));
      end
      prev_req = bus.req;
    end
    i_start = 1'b0;
    check({tag, "_finished"}, 32'(fin), 32'd1);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done"}, 32'(done), 32'(!exp_err));
    check({tag, "_err"},  32'(err),  32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    if (exp_err) check({tag, "_err_idx"}, 32'(err_index), 32'(exp_eidx));
    hi_cycles = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.req) hi_cycles++;
    end
    check({tag, "_idle_req"}, 32'(hi_cycles), 32'd0);
  endtask

  initial begin
    int w;
    // Power-on reset and a 16-entry run with a known word at entry 1.
    fill_random();
    rom[1] = 16'h32FC;
    setup(16, 20, 8'h34);
    repeat (3) @(negedge clk);
    check_reset("rst");
    release_reset();
    run_seq("basic", P_PWRUP + 3, 3);

    // Soft-reset register first: long settle before the second write.
    fill_random();
    rom[0] = {7'h0F, 9'h000};
    setup(16, 20, 8'h34);
    pulse_start();
    run_seq("softrst", 3, -1);

    // Entry 5 NACKed twice, then accepted.
    fill_random();
    plan[5] = 2;
    setup(16, 12, 8'h34);
    pulse_start();
    run_seq("retry", 3, -1);

    // Entry 7 never accepted.
    fill_random();
    plan[7] = P_RETRY + 1;
    setup(16, 9, 8'h34);
    pulse_start();
    run_seq("fail", 3, -1);

    // Empty table after reset, then a full run started from DONE.
    fill_random();
    setup(0, 20, 8'h34);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    run_seq("empty", P_PWRUP + 3, -1);
    setup(16, 20, 8'h34);
    pulse_start();
    run_seq("restart", 3, 5);

    // Reset asserted while a request is outstanding.
    fill_random();
    setup(8, 25, 8'h34);
    pulse_start();
    w = 0;
    while (!bus.req && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("mw_req_seen", 32'(bus.req), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset("mw");
    fill_random();
    setup(6, 7, 8'h1A);
    @(negedge clk);
    release_reset();
    run_seq("mw_recover", P_PWRUP + 3, -1);

    // Randomized tables, latencies and NACK patterns.
    for (int r = 0; r < 8; r++) begin
      int sz;
      fill_random();
      sz = $urandom_range(1, 40);
      for (int i = 0; i < sz; i++)
        plan[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(1, P_RETRY + 1) : 0;
      setup(sz, $urandom_range(1, 30), 8'($urandom));
      pulse_start();
      run_seq("rnd", 3, (r % 2 == 0) ? 2 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
